// File: rtl/flappy_pkg.sv
// Shared types for the flappy game: the game state codes (also decoded by
// the renderer) and the 3-digit BCD score representation.
package flappy_pkg;

    typedef enum logic [1:0] {
        ST_ATTRACT   = 2'd0,
        ST_PLAY      = 2'd1,
        ST_OVER_HOLD = 2'd2,
        ST_OVER_WAIT = 2'd3
    } game_state_t;

    typedef logic [3:0] bcd_digit_t;

    // Hundreds digit is most significant, so the packed vector orders the
    // same way as the decimal value.
    typedef struct packed {
        bcd_digit_t hundreds;
        bcd_digit_t tens;
        bcd_digit_t ones;
    } bcd3_t;

    localparam bcd3_t BCD3_MAX = 12'h999;

endpackage

// File: rtl/bcd_counter3.sv
// 3-digit BCD up-counter that saturates at 999.
// Ports:
//   clk, reset   - clock, synchronous active-high reset (clears count)
//   clr          - synchronous clear, wins over inc
//   inc          - increment by one (no effect at 999)
//   count        - registered count
//   count_next   - value count will take at the next edge
module bcd_counter3
    import flappy_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        inc,
    output logic [11:0] count,
    output logic [11:0] count_next
);

    bcd3_t count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != BCD3_MAX)) begin
            // Ripple the decimal carry; saturation above keeps hundreds <= 9.
            if (count_q.ones != 4'd9) begin
                count_d.ones = count_q.ones + 4'd1;
            end else begin
                count_d.ones = 4'd0;
                if (count_q.tens != 4'd9) begin
                    count_d.tens = count_q.tens + 4'd1;
                end else begin
                    count_d.tens     = 4'd0;
                    count_d.hundreds = count_q.hundreds + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign count_next = count_d;

endmodule

// File: rtl/flappy_game_ctrl.sv
// Game-flow sequencer for the flappy game. Paces physics steps from the
// frame tick, turns flap button edges into per-step flap requests, runs the
// attract / play / game-over sequence and keeps current and best BCD scores.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   frame_tick   - one-cycle pulse per video frame
//   flap_btn     - debounced flap button level
//   bird_alive   - alive flag from physics
//   pipe_passed  - one-cycle pulse per cleared pipe pair
//   phys_reset   - one-cycle clear pulse to physics and pipes
//   phys_step    - one-cycle physics update enable
//   phys_flap    - flap request, qualified by phys_step
//   pipes_run    - pipe scroll enable
//   state        - game state code for the renderer
//   score        - current score, 3-digit BCD
//   high_score   - best score, 3-digit BCD
//   blink        - game-over text blink phase
// All outputs are registered.
module flappy_game_ctrl
    import flappy_pkg::*;
#(
    parameter int STEP_FRAMES  = 1,
    parameter int HOLD_FRAMES  = 60,
    parameter int BLINK_FRAMES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        flap_btn,
    input  logic        bird_alive,
    input  logic        pipe_passed,
    output logic        phys_reset,
    output logic        phys_step,
    output logic        phys_flap,
    output logic        pipes_run,
    output logic [1:0]  state,
    output logic [11:0] score,
    output logic [11:0] high_score,
    output logic        blink
);

    localparam int BLINK_W = $clog2(BLINK_FRAMES) + 1;

    game_state_t        state_q, state_d;
    logic [3:0]         step_cnt_q, step_cnt_d;
    logic [7:0]         hold_cnt_q, hold_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               flap_prev_q, flap_pend_q, flap_pend_d;
    logic               rst_seen_q;
    logic               phys_reset_q, phys_reset_d;
    logic               phys_step_q, phys_step_d;
    logic               phys_flap_q, phys_flap_d;
    logic               pipes_run_q, pipes_run_d;
    logic               blink_q, blink_d;
    bcd3_t              high_q, high_d;
    logic [11:0]        score_next;
    logic               flap_edge, restart, score_inc;
    logic               run_d, step_hit, blink_hit;

    // Packed BCD digits order lexicographically, which equals numeric order.
    function automatic logic bcd3_gt(input bcd3_t a, input bcd3_t b);
        return a > b;
    endfunction

    assign flap_edge = flap_btn & ~flap_prev_q;
    assign score_inc = (state_q == ST_PLAY) && pipe_passed;

    bcd_counter3 u_score (
        .clk        (clk),
        .reset      (reset),
        .clr        (restart),
        .inc        (score_inc),
        .count      (score),
        .count_next (score_next)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ATTRACT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        restart = 1'b0;
        case (state_q)
            ST_ATTRACT:   if (bird_alive) state_d = ST_PLAY;
            ST_PLAY:      if (!bird_alive) state_d = ST_OVER_HOLD;
            ST_OVER_HOLD: if (frame_tick && (hold_cnt_q == 8'(HOLD_FRAMES - 1)))
                              state_d = ST_OVER_WAIT;
            ST_OVER_WAIT: if (flap_edge) begin
                              state_d = ST_ATTRACT;
                              restart = 1'b1;
                          end
            default:      state_d = ST_ATTRACT;
        endcase
    end

    // Output / counter next values. Frame-based counters follow state_d so a
    // tick that lands on a transition is counted under the new state's rules.
    always_comb begin
        run_d    = (state_d == ST_ATTRACT) || (state_d == ST_PLAY);
        step_hit = run_d && frame_tick && (step_cnt_q == 4'(STEP_FRAMES - 1));

        step_cnt_d = '0;
        if (run_d) step_cnt_d = frame_tick ? (step_hit ? 4'd0 : step_cnt_q + 4'd1) : step_cnt_q;

        hold_cnt_d = '0;
        if (state_d == ST_OVER_HOLD) hold_cnt_d = hold_cnt_q + {7'd0, frame_tick};

        blink_hit   = !run_d && frame_tick && (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1));
        blink_cnt_d = '0;
        blink_d     = 1'b0;
        if (!run_d) begin
            blink_cnt_d = frame_tick ? (blink_hit ? '0 : blink_cnt_q + 1'b1) : blink_cnt_q;
            blink_d     = blink_hit ? ~blink_q : blink_q;
        end

        // The restart edge is consumed by the restart and never forwarded.
        phys_step_d = step_hit;
        phys_flap_d = step_hit && !restart && (flap_pend_q || flap_edge);

        flap_pend_d = flap_pend_q;
        if (!run_d || restart || step_hit) flap_pend_d = 1'b0;
        else if (flap_edge)                flap_pend_d = 1'b1;

        // rst_seen_q stretches the reset pulse into the first cycle after reset.
        phys_reset_d = restart || rst_seen_q;
        pipes_run_d  = (state_d == ST_PLAY);

        // score_next already includes a pass in the same cycle as the death.
        high_d = high_q;
        if ((state_q == ST_PLAY) && (state_d == ST_OVER_HOLD) && bcd3_gt(score_next, high_q))
            high_d = score_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            step_cnt_q   <= '0;
            hold_cnt_q   <= '0;
            blink_cnt_q  <= '0;
            blink_q      <= 1'b0;
            flap_prev_q  <= 1'b0;
            flap_pend_q  <= 1'b0;
            phys_reset_q <= 1'b1;
            phys_step_q  <= 1'b0;
            phys_flap_q  <= 1'b0;
            pipes_run_q  <= 1'b0;
            high_q       <= '0;
        end else begin
            step_cnt_q   <= step_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_q      <= blink_d;
            flap_prev_q  <= flap_btn;
            flap_pend_q  <= flap_pend_d;
            phys_reset_q <= phys_reset_d;
            phys_step_q  <= phys_step_d;
            phys_flap_q  <= phys_flap_d;
            pipes_run_q  <= pipes_run_d;
            high_q       <= high_d;
        end
        rst_seen_q <= reset;
    end

    assign phys_reset = phys_reset_q;
    assign phys_step  = phys_step_q;
    assign phys_flap  = phys_flap_q;
    assign pipes_run  = pipes_run_q;
    assign state      = state_q;
    assign high_score = high_q;
    assign blink      = blink_q;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Bench for flappy_game_ctrl: integer-level game model checked every cycle,
// plus directed scenarios with literal expected values.
module tb_flappy_game_ctrl;

    localparam int STEP  = 2;
    localparam int HOLD  = 4;
    localparam int BLINK = 2;

    logic clk = 1'b0;
    logic reset, frame_tick, flap_btn, bird_alive, pipe_passed;
    logic phys_reset, phys_step, phys_flap, pipes_run, blink;
    logic [1:0]  state;
    logic [11:0] score, high_score;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    flappy_game_ctrl #(
        .STEP_FRAMES (STEP),
        .HOLD_FRAMES (HOLD),
        .BLINK_FRAMES(BLINK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .flap_btn   (flap_btn),
        .bird_alive (bird_alive),
        .pipe_passed(pipe_passed),
        .phys_reset (phys_reset),
        .phys_step  (phys_step),
        .phys_flap  (phys_flap),
        .pipes_run  (pipes_run),
        .state      (state),
        .score      (score),
        .high_score (high_score),
        .blink      (blink)
    );

    function automatic logic [11:0] to_bcd(input int v);
        return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (modes: 0 attract,1 play,2 hold,3 wait)
    int m_mode, m_score, m_high, m_frames, m_hold, m_blink_frames;
    bit m_blink, m_pend, m_prev_btn, m_rst_seen;
    bit e_reset, e_step, e_flap, e_pipes;

    always @(posedge clk) begin
        int  nmode;
        bit  edge_now, restart, steps_on, step_now;
        if (reset) begin
            m_mode = 0; m_score = 0; m_high = 0; m_frames = 0; m_hold = 0;
            m_blink_frames = 0; m_blink = 0; m_pend = 0; m_prev_btn = 0;
            e_reset = 1; e_step = 0; e_flap = 0; e_pipes = 0;
            m_rst_seen = 1;
        end else begin
            edge_now = flap_btn && !m_prev_btn;
            nmode    = m_mode;
            restart  = 0;
            if (m_mode == 0 && bird_alive) nmode = 1;
            if (m_mode == 1) begin
                if (pipe_passed && m_score < 999) m_score = m_score + 1;
                if (!bird_alive) begin
                    nmode = 2;
                    if (m_score > m_high) m_high = m_score;
                end
            end
            if (m_mode == 2 && frame_tick && m_hold + 1 == HOLD) nmode = 3;
            if (m_mode == 3 && edge_now) begin
                nmode = 0; restart = 1; m_score = 0;
            end
            steps_on = (nmode <= 1);
            step_now = steps_on && frame_tick && (m_frames + 1 == STEP);
            if (!steps_on) m_frames = 0;
            else if (frame_tick) m_frames = step_now ? 0 : m_frames + 1;
            e_step = step_now;
            e_flap = step_now && !restart && (m_pend || edge_now);
            if (!steps_on || restart || step_now) m_pend = 0;
            else if (edge_now) m_pend = 1;
            m_hold = (nmode == 2) ? m_hold + int'(frame_tick) : 0;
            if (steps_on) begin
                m_blink_frames = 0; m_blink = 0;
            end else if (frame_tick) begin
                m_blink_frames = m_blink_frames + 1;
                if (m_blink_frames == BLINK) begin
                    m_blink_frames = 0; m_blink = !m_blink;
                end
            end
            e_reset    = restart || m_rst_seen;
            m_rst_seen = 0;
            e_pipes    = (nmode == 1);
            m_mode     = nmode;
            m_prev_btn = flap_btn;
        end
    end

    // ---------------- per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_phys_reset", phys_reset, e_reset);
            check("m_phys_step",  phys_step,  e_step);
            check("m_phys_flap",  phys_flap,  e_flap);
            check("m_pipes_run",  pipes_run,  e_pipes);
            check("m_state",      state,      m_mode[1:0]);
            check("m_score",      score,      to_bcd(m_score));
            check("m_high_score", high_score, to_bcd(m_high));
            check("m_blink",      blink,      m_blink);
        end
    end

    // ---------------- directed stimulus
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
    endtask

    task automatic pass_pulse();
        pipe_passed = 1'b1; step(); pipe_passed = 1'b0; step();
    endtask

    initial begin
        int steps_seen;
        reset = 1'b1; frame_tick = 1'b0; flap_btn = 1'b0;
        bird_alive = 1'b0; pipe_passed = 1'b0;
        step();
        chk_en = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
        @(negedge clk);
        check("post_reset_phys_reset", phys_reset, 1);
        check("post_reset_state", state, 0);
        check("post_reset_score", score, 12'h000);
        step();
        @(negedge clk);
        check("phys_reset_drops", phys_reset, 0);

        // six ticks in attract: steps after ticks 2, 4, 6
        steps_seen = 0;
        for (int i = 1; i <= 6; i++) begin
            pulse_tick();
            @(negedge clk);
            check("step_after_tick", phys_step, (i % 2 == 0) ? 1 : 0);
            if (phys_step) steps_seen++;
            step();
            @(negedge clk);
            check("step_one_cycle", phys_step, 0);
        end
        check("step_count", steps_seen, 3);

        // pending flap from an edge 5 cycles before the step
        pulse_tick();
        flap_btn = 1'b1; step(); flap_btn = 1'b0;
        step(); step(); step();
        pulse_tick();
        @(negedge clk);
        check("pend_flap_step", phys_step, 1);
        check("pend_flap", phys_flap, 1);

        // edge in the same cycle as the step
        pulse_tick();
        frame_tick = 1'b1; flap_btn = 1'b1; step(); frame_tick = 1'b0;
        @(negedge clk);
        check("same_cycle_flap", phys_flap, 1);
        flap_btn = 1'b0;
        pulse_tick(); pulse_tick();
        @(negedge clk);
        check("next_step_present", phys_step, 1);
        check("next_step_no_flap", phys_flap, 0);

        // play: 11 passes, then a 12th coinciding with death
        bird_alive = 1'b1; step();
        @(negedge clk);
        check("enter_play_state", state, 1);
        check("enter_play_pipes", pipes_run, 1);
        for (int i = 0; i < 11; i++) pass_pulse();
        pipe_passed = 1'b1; bird_alive = 1'b0; step(); pipe_passed = 1'b0;
        @(negedge clk);
        check("death_score", score, 12'h012);
        check("death_high", high_score, 12'h012);
        check("death_state", state, 2);
        check("death_pipes", pipes_run, 0);

        // over-hold: flap after frame 2 ignored, wait after 4 ticks
        pulse_tick(); step(); pulse_tick();
        @(negedge clk);
        check("blink_on", blink, 1);
        flap_btn = 1'b1; step(); flap_btn = 1'b0; step();
        pulse_tick();
        @(negedge clk);
        check("hold_after_3", state, 2);
        check("hold_no_reset", phys_reset, 0);
        pulse_tick();
        @(negedge clk);
        check("wait_after_4", state, 3);
        flap_btn = 1'b1; step(); flap_btn = 1'b0;
        @(negedge clk);
        check("restart_pulse", phys_reset, 1);
        check("restart_score", score, 12'h000);
        check("restart_state", state, 0);
        check("restart_high", high_score, 12'h012);
        check("restart_no_flap", phys_flap, 0);
        check("restart_blink", blink, 0);
        step();
        @(negedge clk);
        check("restart_pulse_end", phys_reset, 0);

        // reset in the middle of play with score 7
        bird_alive = 1'b1; step();
        for (int i = 0; i < 7; i++) pass_pulse();
        @(negedge clk);
        check("mid_play_score", score, 12'h007);
        reset = 1'b1; step();
        @(negedge clk);
        check("mr_phys_reset", phys_reset, 1);
        check("mr_phys_step", phys_step, 0);
        check("mr_phys_flap", phys_flap, 0);
        check("mr_pipes", pipes_run, 0);
        check("mr_state", state, 0);
        check("mr_score", score, 12'h000);
        check("mr_high", high_score, 12'h000);
        check("mr_blink", blink, 0);
        reset = 1'b0; step(); step();

        // saturation: reach 998, then three more passes
        for (int i = 0; i < 998; i++) pass_pulse();
        @(negedge clk);
        check("score_998", score, 12'h998);
        for (int i = 0; i < 3; i++) begin
            pass_pulse();
            @(negedge clk);
            check("score_sat", score, 12'h999);
        end
        bird_alive = 1'b0; step();
        @(negedge clk);
        check("sat_high", high_score, 12'h999);
        check("sat_state", state, 2);
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/flappy_game_ctrl.md
# flappy_game_ctrl

Game-flow sequencer that owns the bird physics block. It gates the physics update rate to the video frame rate and converts the raw flap button into one-step flap requests. It sequences the attract, play and game-over phases, freezes the pipe scroller, and keeps the BCD current and high scores. It sits between the input conditioning (debounced buttons, vsync-derived frame pulse) and the physics, pipe and renderer blocks.

## Interface
Parameters:
- STEP_FRAMES, 1: frame_tick pulses per physics step (1..15).
- HOLD_FRAMES, 60: frames in OVER_HOLD before a restart is accepted (1..255).
- BLINK_FRAMES, 16: half-period in frames of the game-over blink.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; clock clk.
- frame_tick  in  1  one-cycle pulse per video frame.
- flap_btn  in  1  debounced level, active-high.
- bird_alive  in  1  alive flag from physics.
- pipe_passed  in  1  one-cycle pulse when the bird clears a pipe pair.
- phys_reset  out  1  one-cycle reset pulse to physics and pipes.
- phys_step  out  1  one-cycle physics update enable.
- phys_flap  out  1  flap request, valid only with phys_step.
- pipes_run  out  1  pipe scroll enable.
- state  out  2  game state code, for the renderer.
- score  out  12  3-digit BCD current score.
- high_score  out  12  3-digit BCD best score.
- blink  out  1  game-over text blink phase.

## Operation
- States and codes: ATTRACT=0, PLAY=1, OVER_HOLD=2, OVER_WAIT=3. Shared encoding.
- Flap capture:
  - flap_edge = flap_btn & ~flap_btn_d.
  - An edge sets flap_pend. A step clears flap_pend.
  - phys_flap = phys_step & (flap_pend | flap_edge). An edge in the cycle of a step is used by that step and is not also held pending.
- Step generation:
  - A frame counter counts frame_tick pulses.
  - phys_step pulses in the cycle of the STEP_FRAMES-th tick; the counter then wraps to 0.
  - Steps run in ATTRACT and PLAY only. The counter holds at 0 in the OVER states.
- ATTRACT: pipes_run=0.
  - The first step with phys_flap=1 lets physics start.
  - When bird_alive is seen high -> PLAY.
- PLAY: pipes_run=1.
  - A pipe_passed pulse increments score in BCD, saturating at 999.
  - bird_alive low -> OVER_HOLD.
  - On that transition, if score > high_score, high_score is loaded from score. The comparison is a BCD magnitude compare.
  - A pipe_passed in the same cycle as bird_alive falling is counted before the compare.
- OVER_HOLD: steps and pipes frozen.
  - Counts HOLD_FRAMES frame ticks, then -> OVER_WAIT.
  - Flap edges here are discarded, and flap_pend is cleared on entry.
- OVER_WAIT: on a flap_edge:
  - pulse phys_reset for one cycle;
  - clear score and flap_pend;
  - next state ATTRACT.
  - That edge is not forwarded as a flap.
- blink toggles every BLINK_FRAMES frames in both OVER states and is 0 elsewhere.
- The high score persists across restarts and is cleared only by reset.

## Timing
- Reset values:
  - state=ATTRACT, score=0, high_score=0;
  - phys_step=0, phys_flap=0, pipes_run=0, blink=0;
  - phys_reset=1 for the reset cycle and the first cycle after reset, so physics and pipes are cleared together.
- All outputs are registered. Latencies:
  - phys_step follows the qualifying frame_tick by 1 cycle.
  - phys_flap has the same latency and is aligned with phys_step.
  - score updates 1 cycle after pipe_passed.
  - state changes 1 cycle after the triggering input sample.
- Reset mid-operation wins over every event in that cycle, and the counters clear.
- A frame_tick coinciding with a state change is counted under the new state's rules.
- Score saturation: 999 plus a pass stays at 999, with no wrap.

## Structure
- A shared package flappy_pkg holds:
  - the state enum/codes;
  - the BCD digit type;
  - a 3-digit BCD score type.
- Sub-module bcd_counter3: increment, saturate and clear, reused by the renderer's score path. The magnitude compare lives in the controller.

## Test plan
- Reset, then STEP_FRAMES=2 and 6 frame ticks in ATTRACT -> exactly 3 phys_step pulses, each 1 cycle after the 2nd/4th/6th tick, and phys_reset high in the first post-reset cycle.
- Flap edge 5 cycles before a step, and a separate edge in the same cycle as a step -> phys_flap=1 on each of those steps, and phys_flap=0 on the following step.
- In PLAY, 12 pipe_passed pulses then bird_alive low -> score=0x012, high_score=0x012, state=OVER_HOLD, pipes_run=0.
- Preload score 998 and apply 3 passes -> score=0x999 and holds.
- In OVER_HOLD with HOLD_FRAMES=4, a flap at frame 2 is ignored. After 4 ticks state=OVER_WAIT. A flap then gives one phys_reset pulse, score=0, state=ATTRACT, high_score retained, and no phys_flap.
- Assert reset mid-PLAY with score 7 -> all outputs return to their reset values on the next cycle, and high_score=0.
